smvm_row_scheduler: RTL and testbench

Sequences the sparse matrix-vector multiply datapath one row at a time. Per-row non-zero counts are consumed from an upstream stream, and each count loads an internal down-counter. One element-issue beat is handed to the multiply/accumulate datapath per non-zero, and row-boundary strobes drive the accumulator clear and result write-back. The block sits between the CSR row-pointer fetch logic and the MAC pipeline.

---
 rtl/smvm_row_scheduler.sv | 110 +++++++++++
 tb/tb_smvm_row_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smvm_row_scheduler.sv
// rtl/smvm_row_scheduler.sv - row sequencer feeding per-row non-zero beats to the SpMV MAC datapath
// Optional feature macro: SMVM_SCHED_PERF_EN (stall_cycles back-pressure counter).
module smvm_row_scheduler #(
    parameter int ROW_W = 16,
    parameter int NNZ_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             nnz_valid,
    output logic             nnz_ready,
    input  logic [NNZ_W-1:0] nnz,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [ROW_W-1:0] elem_row,
    output logic             elem_last,
    output logic             acc_clear,
    output logic             row_done,
    output logic             row_empty,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             done,
    output logic [31:0]      stall_cycles
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FINISH} state_t;

    state_t           state, state_nx;
    logic [ROW_W-1:0] rows_q, row_cnt, row_idx_q;
    logic [NNZ_W-1:0] dcnt;
    logic             acc_clear_q, row_done_q, row_empty_q, done_q;
    logic             start_acc, cnt_hs, elem_hs, row_zero, row_adv, last_row;

    always_comb begin
        // The done cycle still reads as busy, so a start there waits one cycle.
        start_acc = (state == IDLE) && start && !done_q;
        cnt_hs    = (state == FETCH) && nnz_valid;
        elem_hs   = (state == ISSUE) && elem_ready;
        row_zero  = cnt_hs && (nnz == '0);
        row_adv   = row_zero || (elem_hs && (dcnt == NNZ_W'(1)));
        last_row  = (row_cnt == rows_q - ROW_W'(1));
        state_nx  = state;
        case (state)
            IDLE:    if (start_acc) state_nx = (num_rows == '0) ? FINISH : FETCH;
            FETCH:   if (cnt_hs) state_nx = row_zero ? (last_row ? FINISH : FETCH) : ISSUE;
            ISSUE:   if (row_adv) state_nx = last_row ? FINISH : FETCH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state       <= IDLE;
            rows_q      <= '0;
            row_cnt     <= '0;
            dcnt        <= '0;
            acc_clear_q <= 1'b0;
            row_done_q  <= 1'b0;
            row_empty_q <= 1'b0;
            row_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            acc_clear_q <= cnt_hs && !row_zero;
            row_done_q  <= row_adv;
            row_empty_q <= row_zero;
            done_q      <= (state == FINISH);
            if (row_adv) row_idx_q <= row_cnt;
            if (start_acc) begin
                rows_q  <= num_rows;
                row_cnt <= '0;
            end else if (row_adv && !last_row) begin
                row_cnt <= row_cnt + ROW_W'(1);
            end
            if (cnt_hs) dcnt <= nnz;
            else if (elem_hs && (dcnt != '0)) dcnt <= dcnt - NNZ_W'(1);
        end
    end

    assign nnz_ready  = (state == FETCH);
    assign elem_valid = (state == ISSUE);
    assign elem_row   = elem_valid ? row_cnt : '0;
    assign elem_last  = elem_valid && (dcnt == NNZ_W'(1));
    assign acc_clear  = acc_clear_q;
    assign row_done   = row_done_q;
    assign row_empty  = row_empty_q;
    assign row_idx    = row_idx_q;
    assign busy       = (state != IDLE) || done_q;
    assign done       = done_q;

`ifdef SMVM_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Survives abort so a cancelled pass can still be profiled.
    always_ff @(posedge clk) begin
        if (rst || (start_acc && !abort)) begin
            stall_q <= '0;
        end else if (elem_valid && !elem_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_smvm_row_scheduler.sv
// tb/tb_smvm_row_scheduler.sv - self-checking bench for smvm_row_scheduler
module tb_smvm_row_scheduler;
    localparam int ROW_W = 16;
    localparam int NNZ_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, abort, nnz_valid, elem_ready;
    logic [ROW_W-1:0] num_rows;
    logic [NNZ_W-1:0] nnz;
    logic             nnz_ready, elem_valid, elem_last, acc_clear, row_done, row_empty, busy, done;
    logic [ROW_W-1:0] elem_row, row_idx;
    logic [31:0]      stall_cycles;

    smvm_row_scheduler #(.ROW_W(ROW_W), .NNZ_W(NNZ_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_rows(num_rows),
        .nnz_valid(nnz_valid), .nnz_ready(nnz_ready), .nnz(nnz),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_row(elem_row),
        .elem_last(elem_last), .acc_clear(acc_clear), .row_done(row_done),
        .row_empty(row_empty), .row_idx(row_idx), .busy(busy), .done(done),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one pass: expected element beats, row completions and the count feed.
    int feed_q[$];
    int exp_elem_row[$];
    bit exp_elem_last[$];
    int exp_rd_idx[$];
    bit exp_rd_empty[$];
    int log_row[$];
    bit log_last[$];
    bit log_empty[$];
    int clear_cnt, done_cnt, hs_cnt, busy_cnt, rdy_cnt, val_cnt;
    bit pend_clear, pend_rd, prev_stalled, prev_last, check_en;
    int prev_row;
    bit [1:0] done_sched;
    int stall_model;
    int t_row;
    bit t_bit, exp_done;

    task automatic plan_row(input int r, input int c);
        feed_q.push_back(c);
        for (int k = 0; k < c; k++) begin
            exp_elem_row.push_back(r);
            exp_elem_last.push_back(k == c - 1);
        end
        exp_rd_idx.push_back(r);
        exp_rd_empty.push_back(c == 0);
    endtask

    function automatic int exp_stall();
`ifdef SMVM_SCHED_PERF_EN
        return stall_model;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            exp_done = done_sched[0];
            chk("acc_clear", 32'(acc_clear), 32'(pend_clear));
            chk("row_done", 32'(row_done), 32'(pend_rd));
            chk("done", 32'(done), 32'(exp_done));
            chk("stall_cycles", stall_cycles, exp_stall());
            chk("ready_valid_excl", 32'(nnz_ready & elem_valid), 32'd0);
            if (pend_clear) chk("valid_after_count", 32'(elem_valid), 32'd1);
            if (prev_stalled) begin
                chk("hold_valid", 32'(elem_valid), 32'd1);
                chk("hold_row", 32'(elem_row), prev_row);
                chk("hold_last", 32'(elem_last), 32'(prev_last));
            end
            done_sched = done_sched >> 1;
            if (done) done_cnt++;
            if (acc_clear) clear_cnt++;
            busy_cnt += int'(busy);
            rdy_cnt  += int'(nnz_ready);
            val_cnt  += int'(elem_valid);
            pend_clear   = 1'b0;
            pend_rd      = 1'b0;
            prev_stalled = 1'b0;
            if (!rst && elem_valid && !elem_ready) stall_model++;
            if (rst || abort) begin
                exp_elem_row.delete();
                exp_elem_last.delete();
                exp_rd_idx.delete();
                exp_rd_empty.delete();
                done_sched = 2'b00;
                if (rst) stall_model = 0;
            end else begin
                if (start && !busy) begin
                    stall_model = 0;
                    if (num_rows == '0) done_sched = 2'b10;
                end
                if (row_done) begin
                    if (exp_rd_idx.size() == 0) begin
                        chk("row_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        t_row = exp_rd_idx.pop_front();
                        t_bit = exp_rd_empty.pop_front();
                        chk("row_idx", 32'(row_idx), t_row);
                        chk("row_empty", 32'(row_empty), 32'(t_bit));
                        log_empty.push_back(row_empty);
                        if (exp_rd_idx.size() == 0) done_sched[0] = 1'b1;
                    end
                end
                if (nnz_valid && nnz_ready) begin
                    if (nnz != '0) pend_clear = 1'b1;
                    else pend_rd = 1'b1;
                end
                if (elem_valid && elem_ready) begin
                    hs_cnt++;
                    log_row.push_back(int'(elem_row));
                    log_last.push_back(elem_last);
                    if (exp_elem_row.size() == 0) begin
                        chk("elem_unexpected", 32'd1, 32'd0);
                    end else begin
                        t_row = exp_elem_row.pop_front();
                        t_bit = exp_elem_last.pop_front();
                        chk("elem_row", 32'(elem_row), t_row);
                        chk("elem_last", 32'(elem_last), 32'(t_bit));
                        if (t_bit) pend_rd = 1'b1;
                    end
                end
                if (elem_valid && !elem_ready) begin
                    prev_stalled = 1'b1;
                    prev_row     = int'(elem_row);
                    prev_last    = elem_last;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_nnz_ready"}, 32'(nnz_ready), 32'd0);
        chk({tag, "_elem_valid"}, 32'(elem_valid), 32'd0);
        chk({tag, "_elem_row"}, 32'(elem_row), 32'd0);
        chk({tag, "_elem_last"}, 32'(elem_last), 32'd0);
        chk({tag, "_acc_clear"}, 32'(acc_clear), 32'd0);
        chk({tag, "_row_done"}, 32'(row_done), 32'd0);
        chk({tag, "_row_empty"}, 32'(row_empty), 32'd0);
        chk({tag, "_row_idx"}, 32'(row_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_stall"}, stall_cycles, 32'd0);
    endtask

    // mode 0: elem_ready held high; mode 1: elem_ready pattern 1,0,0 by cycle.
    task automatic run_pass(input int nrows, input int mode, input int busy_start_at,
                            input int rst_at, input int budget);
        bit hs, rst_fired;
        int cyc;
        done_cnt = 0; clear_cnt = 0; hs_cnt = 0;
        busy_cnt = 0; rdy_cnt = 0; val_cnt = 0;
        log_row.delete(); log_last.delete(); log_empty.delete();
        num_rows  = ROW_W'(nrows);
        start     = 1'b1;
        cyc       = 0;
        rst_fired = 1'b0;
        while (cyc < budget && done_cnt == 0 && !rst_fired) begin
            nnz_valid  = (feed_q.size() != 0);
            nnz        = nnz_valid ? NNZ_W'(feed_q[0]) : '0;
            elem_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (cyc == busy_start_at) begin
                start    = 1'b1;
                num_rows = ROW_W'(5);
            end
            if (cyc == rst_at) rst = 1'b1;
            hs = nnz_valid && nnz_ready;
            @(posedge clk); #1;
            if (hs) void'(feed_q.pop_front());
            start = 1'b0;
            if (rst) begin
                rst_fired = 1'b1;
                check_all_zero("mid_rst");
                rst = 1'b0;
            end
            cyc++;
        end
        nnz_valid  = 1'b0;
        elem_ready = 1'b0;
        if (!rst_fired) begin
            chk("pass_done_count", done_cnt, 1);
            chk("leftover_elems", exp_elem_row.size(), 0);
            chk("leftover_rows", exp_rd_idx.size(), 0);
            chk("leftover_feed", feed_q.size(), 0);
            chk("idle_after_pass", 32'(busy), 32'd0);
        end
    endtask

    int lit_row[5]  = '{0, 0, 2, 2, 2};
    bit lit_last[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit lit_empty[3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; nnz_valid = 1'b0; nnz = '0;
        elem_ready = 1'b0; num_rows = '0; check_en = 1'b0;
        pend_clear = 1'b0; pend_rd = 1'b0; prev_stalled = 1'b0; done_sched = 2'b00;
        stall_model = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Three rows {2,0,3}, full throughput.
        plan_row(0, 2); plan_row(1, 0); plan_row(2, 3);
        run_pass(3, 0, -1, -1, 60);
        chk("t1_handshakes", hs_cnt, 5);
        chk("t1_acc_clears", clear_cnt, 2);
        chk("t1_row_dones", log_empty.size(), 3);
        for (int i = 0; i < 5; i++) begin
            chk("t1_beat_row", (i < log_row.size()) ? log_row[i] : -1, lit_row[i]);
            chk("t1_beat_last", (i < log_last.size()) ? 32'(log_last[i]) : 32'hFF, 32'(lit_last[i]));
        end
        for (int i = 0; i < 3; i++)
            chk("t1_row_empty", (i < log_empty.size()) ? 32'(log_empty[i]) : 32'hFF, 32'(lit_empty[i]));

        // Empty pass.
        run_pass(0, 0, -1, -1, 10);
        chk("t2_busy_cycles", busy_cnt, 2);
        chk("t2_nnz_ready_cycles", rdy_cnt, 0);
        chk("t2_elem_valid_cycles", val_cnt, 0);

        // Back-pressure on a 4-element row.
        plan_row(0, 4);
        run_pass(1, 1, -1, -1, 80);
        chk("t3_handshakes", hs_cnt, 4);
`ifdef SMVM_SCHED_PERF_EN
        chk("t3_stall_total", stall_cycles, 32'd7);
`else
        chk("t3_stall_total", stall_cycles, 32'd0);
`endif

        // Abort after two of five elements, then a clean single-row pass.
        plan_row(0, 5); plan_row(1, 1);
        done_cnt = 0;
        start = 1'b1; num_rows = ROW_W'(2); nnz_valid = 1'b1; nnz = NNZ_W'(5); elem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        nnz_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        elem_ready = 1'b0;
        chk("t4_busy_after_abort", 32'(busy), 32'd0);
        chk("t4_valid_after_abort", 32'(elem_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt, 0);
        feed_q.delete();
        plan_row(0, 1);
        run_pass(1, 0, -1, -1, 40);
        chk("t4_restart_handshakes", hs_cnt, 1);

        // Start while busy is ignored.
        plan_row(0, 1); plan_row(1, 2);
        run_pass(2, 0, 3, -1, 60);
        chk("t5_handshakes", hs_cnt, 3);
        chk("t5_acc_clears", clear_cnt, 2);

        // Reset in the middle of a stalled pass.
        plan_row(0, 3); plan_row(1, 1);
        run_pass(2, 1, -1, 6, 40);
        feed_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle_after_rst", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
